// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared constants, state encoding and helper functions for the
//             sequential BCD-to-binary converter.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

   // Width of one packed BCD digit
   localparam int BCD_DIGIT_W = 4;

   // Largest legal decimal digit value
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

   // Converter state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Ceiling log2, usable in constant expressions
   function automatic int bcd_clog2(input int v);
      int r;
      r = 0;
      while ((longint'(1) << r) < longint'(v)) r++;
      return r;
   endfunction

   // 10^n, used to check that the binary field can hold every BCD word
   function automatic longint bcd_pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_bin_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin_seq_if
//  Purpose  : Input (BCD word) and output (binary result) handshake channels
//             of the BCD-to-binary converter.
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_to_bin_seq_if
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
);

   logic                            in_valid;
   logic                            in_ready;
   logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_in;
   logic                            out_valid;
   logic                            out_ready;
   logic [BIN_W-1:0]                bin_out;
   logic                            err;

   // Producer of BCD words and consumer of results
   modport master (
      output in_valid,
      output bcd_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bin_out,
      input  err
   );

   // The converter itself
   modport slave (
      input  in_valid,
      input  bcd_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bin_out,
      output err
   );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_corr.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_corr
//  Purpose  : Per-digit correction of the reverse double-dabble step:
//             subtract 3 from a digit that is 8 or more after the shift.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_corr
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);

   // A digit >= 8 after a right shift carried a half-ten (5) in from the
   // digit above; binary weight 8 minus decimal weight 5 leaves 3 to remove.
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd8)
         o_digit = i_digit - 4'd3;
   end

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin_seq
//  Purpose  : Sequential BCD-to-binary converter (reverse double-dabble).
//             One shift/correct step per clock; words containing a digit
//             above 9 are rejected with err instead of being converted.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
)(
   input  logic               clk,
   input  logic               reset,
   bcd_to_bin_seq_if.slave    bus
);

   localparam int c_BCD_W  = BCD_DIGIT_W * DIGITS;
   localparam int c_WORK_W = c_BCD_W + BIN_W;
   localparam int c_CNT_W  = bcd_clog2(BIN_W) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

   // The binary field must be able to hold the largest decimal word
   generate
      if ((longint'(1) << BIN_W) < bcd_pow10(DIGITS)) begin : g_bad_width
         $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
      end
   endgenerate

   logic [1:0]            r_state;
   logic [c_WORK_W-1:0]   r_work;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_out_valid;
   logic [BIN_W-1:0]      r_bin;
   logic                  r_err;

   logic [c_WORK_W-1:0]   w_shift;
   logic [c_WORK_W-1:0]   w_next;
   logic                  w_bad;

   assign w_shift = r_work >> 1;

   // Binary field passes straight through the step; only BCD digits correct
   assign w_next[BIN_W-1:0] = w_shift[BIN_W-1:0];

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_corr
         bcd_digit_corr u_corr (
            .i_digit (w_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_next [BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   // Flag an incoming word holding any digit above 9
   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.bcd_in[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
            w_bad = 1'b1;
      end
   end

   // Control FSM, working register and registered result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_work      <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_bin       <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_work  <= {bus.bcd_in, {BIN_W{1'b0}}};
                  r_cnt   <= '0;
                  r_bin   <= '0;
                  r_err   <= w_bad;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               if (r_err) begin
                  // Rejected word: report after one cycle, result stays 0
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_work <= w_next;
                  r_cnt  <= r_cnt + c_CNT_W'(1);
                  if (r_cnt == c_LAST) begin
                     r_bin       <= w_next[BIN_W-1:0];
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.bin_out   = r_bin;
   assign bus.err       = r_err;

endmodule
`default_nettype wire
